// File: rtl/matrix_feeder.sv
`default_nettype none
// ============================================================================
// matrix_feeder : buffers A/B operand matrices and issues skewed wavefronts
// Revision      : 1.0  initial release
// ============================================================================
module matrix_feeder #(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int PERIOD = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [$clog2(N*N)-1:0] wr_addr,
  input  logic [DW-1:0]          wr_data,
  input  logic                   start,
  output logic [N*DW-1:0]        row_data,
  output logic [N*DW-1:0]        col_data,
  output logic                   feed_ready,
  output logic                   busy,
  output logic                   finished
);

  localparam int c_bw = $clog2(3*N-2);
  localparam int c_pw = $clog2(PERIOD);
  localparam logic [c_bw-1:0] c_beat_last = c_bw'(3*N-3);
  localparam logic [c_pw-1:0] c_per_last  = c_pw'(PERIOD-2);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_fin   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [c_bw-1:0] beat_q, beat_d;
  logic [c_pw-1:0] per_q, per_d;
  logic [N*DW-1:0] row_q, row_d;
  logic [N*DW-1:0] col_q, col_d;
  logic            feed_ready_q, feed_ready_d;
  logic            busy_q, busy_d;
  logic            finished_q, finished_d;

  logic [DW-1:0]   a_mem_q [N*N];
  logic [DW-1:0]   a_mem_d [N*N];
  logic [DW-1:0]   b_mem_q [N*N];
  logic [DW-1:0]   b_mem_d [N*N];

  logic            wr_ok;
  logic [c_bw-1:0] next_beat;
  logic [N*DW-1:0] beat_row;
  logic [N*DW-1:0] beat_col;

  // Writes are blocked during reset so an asserted rst_n cannot corrupt the buffer.
  assign wr_ok = rst_n && wr_en && (state_q == c_st_idle) && (int'(wr_addr) < N*N);

  always_comb begin
    a_mem_d = a_mem_q;
    b_mem_d = b_mem_q;
    if (wr_ok) begin
      if (wr_sel) begin
        b_mem_d[wr_addr] = wr_data;
      end else begin
        a_mem_d[wr_addr] = wr_data;
      end
    end
  end

  assign next_beat = (state_q == c_st_idle) ? '0 : beat_q + 1'b1;

  // Beat data is taken from the post-write buffer so a same-cycle write reaches beat 0.
  always_comb begin
    beat_row = '0;
    beat_col = '0;
    for (int i = 0; i < N; i++) begin
      for (int d = 0; d < N; d++) begin
        if (int'(next_beat) == i + d) begin
          beat_row[i*DW +: DW] = a_mem_d[i*N + d];
          beat_col[i*DW +: DW] = b_mem_d[d*N + i];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    per_d   = per_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      c_st_idle: begin
        if (start) begin
          state_d = c_st_issue;
          beat_d  = '0;
          row_d   = beat_row;
          col_d   = beat_col;
        end
      end
      c_st_issue: begin
        state_d = c_st_wait;
        per_d   = '0;
      end
      c_st_wait: begin
        if (per_q == c_per_last) begin
          per_d = '0;
          if (beat_q == c_beat_last) begin
            state_d = c_st_fin;
          end else begin
            state_d = c_st_issue;
            beat_d  = next_beat;
            row_d   = beat_row;
            col_d   = beat_col;
          end
        end else begin
          per_d = per_q + 1'b1;
        end
      end
      c_st_fin: begin
        state_d = c_st_idle;
        beat_d  = '0;
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  assign feed_ready_d = (state_d == c_st_issue);
  assign finished_d   = (state_d == c_st_fin);
  assign busy_d       = (state_d != c_st_idle);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= c_st_idle;
      beat_q       <= '0;
      per_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      feed_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      per_q        <= per_d;
      row_q        <= row_d;
      col_q        <= col_d;
      feed_ready_q <= feed_ready_d;
      busy_q       <= busy_d;
      finished_q   <= finished_d;
    end
  end

  // Operand buffer survives reset.
  always_ff @(posedge clk) begin
    a_mem_q <= a_mem_d;
    b_mem_q <= b_mem_d;
  end

  assign row_data   = row_q;
  assign col_data   = col_q;
  assign feed_ready = feed_ready_q;
  assign busy       = busy_q;
  assign finished   = finished_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_feeder.sv
`default_nettype none
// ============================================================================
// tb_matrix_feeder : self-checking bench for matrix_feeder (N=2, PERIOD=12)
// Revision         : 1.0  initial release
// ============================================================================
module tb_matrix_feeder;

  localparam int N       = 2;
  localparam int DW      = 8;
  localparam int PERIOD  = 12;
  localparam int AW      = $clog2(N*N);
  localparam int BEATS   = 3*N-2;
  localparam int RUN_LEN = BEATS*PERIOD;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0;
  logic            wr_sel = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            start = 1'b0;
  logic [N*DW-1:0] row_data;
  logic [N*DW-1:0] col_data;
  logic            feed_ready;
  logic            busy;
  logic            finished;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ma [N*N];
  logic [DW-1:0] mb [N*N];

  typedef struct {
    int              rel;
    logic [N*DW-1:0] row;
    logic [N*DW-1:0] col;
    logic            rdy;
    logic            fin;
  } vec_t;

  vec_t tbl [9];

  matrix_feeder #(.N(N), .DW(DW), .PERIOD(PERIOD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .row_data   (row_data),
    .col_data   (col_data),
    .feed_ready (feed_ready),
    .busy       (busy),
    .finished   (finished)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_row"},   64'(row_data),   64'(0));
    chk({tag, "_col"},   64'(col_data),   64'(0));
    chk({tag, "_ready"}, 64'(feed_ready), 64'(0));
    chk({tag, "_busy"},  64'(busy),       64'(0));
    chk({tag, "_fin"},   64'(finished),   64'(0));
  endtask

  // Skewed wavefront straight from the matrix definition: row i sees A[i][k-i].
  function automatic logic [N*DW-1:0] exp_row(input int k);
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      if (k - i >= 0 && k - i < N) v[i*DW +: DW] = ma[i*N + (k - i)];
    return v;
  endfunction

  function automatic logic [N*DW-1:0] exp_col(input int k);
    logic [N*DW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++)
      if (k - j >= 0 && k - j < N) v[j*DW +: DW] = mb[(k - j)*N + j];
    return v;
  endfunction

  task automatic write(input bit sel, input int addr, input logic [DW-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = data;
    step();
    wr_en = 1'b0;
    if (addr < N*N) begin
      if (sel) mb[addr] = data; else ma[addr] = data;
    end
  endtask

  // noise: 0 quiet, 1 start+write A[0][0]=9 at t+5, 2 random requests every busy cycle.
  // abort_c > 0 drops rst_n for one cycle at t+abort_c and returns in t+abort_c+1.
  task automatic run(input bit do_wr, input bit sel, input int addr, input logic [DW-1:0] data,
                     input int noise, input int abort_c);
    int pulses;
    int k;
    pulses = 0;
    start = 1'b1;
    if (do_wr) begin
      wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = data;
      if (addr < N*N) begin
        if (sel) mb[addr] = data; else ma[addr] = data;
      end
    end
    step();
    start = 1'b0; wr_en = 1'b0;
    for (int c = 1; c <= RUN_LEN + 1; c++) begin
      k = (c - 1) / PERIOD;
      if (noise == 2) begin
        start = 1'($urandom); wr_en = 1'($urandom); wr_sel = 1'($urandom);
        wr_addr = AW'($urandom); wr_data = DW'($urandom);
      end else if (noise == 1) begin
        start = (c == 5); wr_en = (c == 5); wr_sel = 1'b0; wr_addr = '0; wr_data = 8'd9;
      end
      if (c == abort_c) rst_n = 1'b0;
      @(negedge clk);
      chk("feed_ready", 64'(feed_ready), 64'((((c - 1) % PERIOD) == 0) && (c <= RUN_LEN)));
      chk("finished",   64'(finished),   64'(c == RUN_LEN + 1));
      chk("busy",       64'(busy),       64'(1));
      chk("row_data",   64'(row_data),   64'(exp_row(k)));
      chk("col_data",   64'(col_data),   64'(exp_col(k)));
      if (feed_ready) pulses++;
      step();
      if (c == abort_c) begin
        start = 1'b0; wr_en = 1'b0;
        return;
      end
    end
    start = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    chk("busy_fall",    64'(busy),       64'(0));
    chk("fin_single",   64'(finished),   64'(0));
    chk("ready_idle",   64'(feed_ready), 64'(0));
    chk("ready_pulses", 64'(pulses),     64'(BEATS));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got timeout expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    int nw;

    tbl[0] = '{1,  16'h0001, 16'h0005, 1'b1, 1'b0};
    tbl[1] = '{2,  16'h0001, 16'h0005, 1'b0, 1'b0};
    tbl[2] = '{12, 16'h0001, 16'h0005, 1'b0, 1'b0};
    tbl[3] = '{13, 16'h0302, 16'h0607, 1'b1, 1'b0};
    tbl[4] = '{25, 16'h0400, 16'h0800, 1'b1, 1'b0};
    tbl[5] = '{37, 16'h0000, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{48, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[7] = '{49, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[8] = '{50, 16'h0000, 16'h0000, 1'b0, 1'b0};

    rst_n = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk_zero("init_rst");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < N*N; i++) write(1'b0, i, DW'(i + 1));
    for (int i = 0; i < N*N; i++) write(1'b1, i, DW'(i + 5));

    // Basic 2x2 schedule against hand-derived checkpoints.
    np = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= RUN_LEN + 2; c++) begin
      @(negedge clk);
      for (int v = 0; v < 9; v++) begin
        if (tbl[v].rel == c) begin
          chk("tbl_row",   64'(row_data),   64'(tbl[v].row));
          chk("tbl_col",   64'(col_data),   64'(tbl[v].col));
          chk("tbl_ready", 64'(feed_ready), 64'(tbl[v].rdy));
          chk("tbl_fin",   64'(finished),   64'(tbl[v].fin));
        end
      end
      if (feed_ready) np++;
      step();
    end
    chk("tbl_pulses", 64'(np), 64'(4));

    // Reset during a run with start and a write held high.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    rst_n = 1'b0; start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'h55;
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      chk_zero("rst");
    end
    rst_n = 1'b1; start = 1'b0; wr_en = 1'b0;
    step();
    @(negedge clk);
    chk_zero("post_rst");
    run(1'b0, 1'b0, 0, 8'd0, 0, 0);

    // Extreme signed values must pass through bit-exact.
    write(1'b0, 0, 8'h80);
    write(1'b1, 0, 8'hFF);
    run(1'b0, 1'b0, 0, 8'd0, 0, 0);

    // Requests during a run are ignored, buffer keeps the old A[0][0].
    run(1'b0, 1'b0, 0, 8'd0, 1, 0);
    run(1'b0, 1'b0, 0, 8'd0, 0, 0);

    // Same-cycle write and start.
    run(1'b1, 1'b0, 0, 8'd7, 0, 0);

    // Mid-run reset, then a clean restart at t+30.
    run(1'b0, 1'b0, 0, 8'd0, 0, 20);
    rst_n = 1'b1;
    for (int c = 21; c < 30; c++) begin
      @(negedge clk);
      chk_zero("abort");
      step();
    end
    run(1'b0, 1'b0, 0, 8'd0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      nw = int'($urandom_range(0, 4));
      for (int w = 0; w < nw; w++)
        write(1'($urandom), int'($urandom_range(0, N*N - 1)), DW'($urandom));
      run(1'($urandom), 1'($urandom), int'($urandom_range(0, N*N - 1)), DW'($urandom), 2, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_feeder.md
# matrix_feeder

Upstream stage of the systolic matrix multiplier. It buffers two N×N signed 8-bit operand matrices, A and B, and injects them into the array's left and top edges as diagonally skewed wavefronts. Each wavefront is paced to the processing-element cycle, so every edge PE gets one operand pair per multiply. The feeder drives the edge PEs' `in_data1`/`in_data2` and their shared `ready` strobe.

## Interface
- `N`, default 4: array dimension (2..8).
- `DW`, default 8: operand width.
- `PERIOD`, default 12: cycles between beats. This is the PE accept-to-accept interval: 1 IDLE cycle + 9 CALC cycles + DONE1 + DONE2. Minimum 2.
- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  operand write strobe, honoured only while idle.
- `wr_sel`  in  1  target matrix: 0 = A, 1 = B.
- `wr_addr`  in  $clog2(N*N)  element address, row*N + col.
- `wr_data`  in  DW  signed element value.
- `start`  in  1  single-cycle request to begin feeding, honoured only while idle.
- `row_data`  out  N*DW  left-edge operands; lane i at [i*DW +: DW] drives `in_data1` of row i.
- `col_data`  out  N*DW  top-edge operands; lane j at [j*DW +: DW] drives `in_data2` of column j.
- `feed_ready`  out  1  single-cycle beat strobe, broadcast to the edge PEs' `ready`.
- `busy`  out  1  high from the cycle after an accepted `start` until `finished`, inclusive.
- `finished`  out  1  single-cycle pulse when the final beat period expires.

## Operation
- States:
  - IDLE: accepts writes and `start`.
  - ISSUE: loads the beat data and pulses `feed_ready`.
  - WAIT: counts PERIOD-1 cycles.
  - FIN: pulses `finished`, then returns to IDLE.
- Total beats: 3N-2. Beat index k runs from 0 to 3N-3.
- Beat k data:
  - row lane i = A[i][k-i] if 0 ≤ k-i < N, else 0.
  - col lane j = B[k-j][j] if 0 ≤ k-j < N, else 0.
  - Beats 2N-1 through 3N-3 are all-zero drain beats. They let the pass-through data reach the far PEs.
- `row_data` and `col_data` are registered. They change only in the ISSUE cycle and are held stable for the whole period, because the PE re-samples its inputs at the end of CALC for pass-through.
- Writes land in a 2×N×N register buffer. A write and `start` in the same IDLE cycle are legal: the write takes effect and beat 0 uses the updated value.
- Ignored inputs:
  - `wr_en` while busy.
  - `start` while busy or in FIN.
  - An out-of-range `wr_addr` (≥ N*N).
- Arithmetic: values pass through unchanged with no sign extension or truncation. Beat counter width is $clog2(3N-2); period counter width is $clog2(PERIOD).

## Timing
- Reset (rst_n low at a rising edge) forces:
  - state to IDLE;
  - `row_data`, `col_data`, `feed_ready`, `busy` and `finished` to 0;
  - both counters to 0.
- Reset does not clear the operand buffer; its contents are preserved.
- Reset mid-feed aborts immediately. No `finished` is produced, and the next `start` restarts from beat 0.
- `start` sampled at cycle t:
  - beat k data is valid and `feed_ready` = 1 at cycle t+1+k*PERIOD;
  - `feed_ready` is low in all other cycles.
- `finished` = 1 at cycle t+1+(3N-2)*PERIOD. `busy` falls the following cycle.
- The earliest re-accepted `start` is in the cycle after `finished`.

## Test plan
- Reset values: hold rst_n low 3 cycles with `start` = 1 and `wr_en` = 1 → all outputs 0, state IDLE; a write attempted during reset is not visible in the next run.
- Basic 2×2 run (N=2, PERIOD=12): A={{1,2},{3,4}}, B={{5,6},{7,8}}, `start` at t → required outputs:
  - t+1: row=(1,0), col=(5,0).
  - t+13: row=(2,3), col=(7,6).
  - t+25: row=(0,4), col=(0,8).
  - t+37: all zero.
  - t+49: `finished` = 1; exactly 4 `feed_ready` pulses.
- Negative values: A[0][0] = -128 (0x80), B[0][0] = -1 (0xFF) → beat 0 lanes carry exactly 0x80 and 0xFF, and data is stable across all 12 cycles.
- Ignored requests: `start` and a write to A[0][0] = 9 issued at t+5 during a run → no restart, the beat schedule is unchanged, and the next run still shows the old A[0][0].
- Same-cycle write and start: write A[0][0] = 7 together with `start` → beat 0 row lane 0 = 7.
- Mid-run reset: deassert rst_n at t+20 for 1 cycle → outputs 0 and no `finished`; a `start` at t+30 reproduces the full beat schedule from t+31.
